// File: rtl/sdram_fifo_sched_if.sv
// Handshake bundle between the FIFO/SDRAM scheduler and its surroundings.
// master = scheduler side, slave = FIFO glue plus SDRAM controller side.
interface sdram_fifo_sched_if;
    logic        init_end;
    logic [9:0]  wr_fifo_num;
    logic [9:0]  rd_fifo_num;
    logic        read_valid;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic        sdram_wr_req;
    logic [23:0] sdram_wr_addr;
    logic [9:0]  wr_burst_len;
    logic        sdram_rd_req;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  rd_burst_len;
    logic        wr_fifo_rd_en;
    logic        rd_fifo_wr_en;
    logic [24:0] fill_words;
    logic        sched_err;

    modport master (
        input  init_end, wr_fifo_num, rd_fifo_num, read_valid, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_wr_addr, wr_burst_len, sdram_rd_req, sdram_rd_addr,
               rd_burst_len, wr_fifo_rd_en, rd_fifo_wr_en, fill_words, sched_err
    );

    modport slave (
        output init_end, wr_fifo_num, rd_fifo_num, read_valid, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_wr_addr, wr_burst_len, sdram_rd_req, sdram_rd_addr,
               rd_burst_len, wr_fifo_rd_en, rd_fifo_wr_en, fill_words, sched_err
    );
endinterface

// File: rtl/sdram_fifo_sched.sv
// Ring-buffer burst scheduler between local FIFOs and the SDRAM controller.
// Optional watchdog enabled by defining SDRAM_FIFO_SCHED_TIMEOUT_EN.
module sdram_fifo_sched #(
    parameter logic [23:0] ADDR_BEGIN    = 24'd0,
    parameter logic [23:0] ADDR_END      = 24'd1000,
    parameter logic [9:0]  BURST_LEN     = 10'd10,
    parameter logic [9:0]  RD_FIFO_LIMIT = 10'd16,
    parameter logic [15:0] TIMEOUT_CYC   = 16'd1000
) (
    input logic                sys_clk,
    input logic                sys_rst_n,
    sdram_fifo_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

    localparam logic [24:0] REGION  = {1'b0, ADDR_END} - {1'b0, ADDR_BEGIN};
    localparam logic [24:0] BURST_W = {15'd0, BURST_LEN};

    state_t      state, state_nxt;
    logic        last_rd;
    logic        wr_ack_d, rd_ack_d;
    logic        wr_req_q, rd_req_q;
    logic [23:0] wr_addr, rd_addr, wr_addr_nxt, rd_addr_nxt;
    logic [24:0] fill, wr_sum, rd_sum;
    logic        wr_ok, rd_ok, grant_wr, grant_rd;
    logic        wr_done, rd_done, timeout;

    always_comb begin
        wr_ok    = bus.init_end && (bus.wr_fifo_num >= BURST_LEN) && (fill + BURST_W <= REGION);
        rd_ok    = bus.init_end && bus.read_valid && (fill >= BURST_W)
                   && (bus.rd_fifo_num < RD_FIFO_LIMIT);
        // On a tie the side that did not win last time gets the grant.
        grant_wr = (state == IDLE) && wr_ok && (!rd_ok || last_rd);
        grant_rd = (state == IDLE) && rd_ok && !grant_wr;
        wr_done  = (state == WR_BURST) && wr_ack_d && !bus.sdram_wr_ack && !timeout;
        rd_done  = (state == RD_BURST) && rd_ack_d && !bus.sdram_rd_ack && !timeout;
        wr_sum      = {1'b0, wr_addr} + BURST_W;
        rd_sum      = {1'b0, rd_addr} + BURST_W;
        wr_addr_nxt = (wr_sum == {1'b0, ADDR_END}) ? ADDR_BEGIN : wr_sum[23:0];
        rd_addr_nxt = (rd_sum == {1'b0, ADDR_END}) ? ADDR_BEGIN : rd_sum[23:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_wr)      state_nxt = WR_REQ;
                else if (grant_rd) state_nxt = RD_REQ;
            end
            WR_REQ:   if (bus.sdram_wr_ack) state_nxt = WR_BURST;
            WR_BURST: if (wr_done)          state_nxt = IDLE;
            RD_REQ:   if (bus.sdram_rd_ack) state_nxt = RD_BURST;
            RD_BURST: if (rd_done)          state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            last_rd  <= 1'b1;
            wr_ack_d <= 1'b0;
            rd_ack_d <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            wr_addr  <= ADDR_BEGIN;
            rd_addr  <= ADDR_BEGIN;
            fill     <= '0;
        end else begin
            state    <= state_nxt;
            wr_ack_d <= bus.sdram_wr_ack;
            rd_ack_d <= bus.sdram_rd_ack;
            wr_req_q <= (state_nxt == WR_REQ);
            rd_req_q <= (state_nxt == RD_REQ);
            if (grant_wr)      last_rd <= 1'b0;
            else if (grant_rd) last_rd <= 1'b1;
            if (wr_done) begin
                wr_addr <= wr_addr_nxt;
                fill    <= fill + BURST_W;
            end else if (rd_done) begin
                rd_addr <= rd_addr_nxt;
                fill    <= fill - BURST_W;
            end
        end
    end

`ifdef SDRAM_FIFO_SCHED_TIMEOUT_EN
    logic [15:0] busy_cnt;
    logic        err_q;

    assign timeout = (state != IDLE) && (busy_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            busy_cnt <= (state == IDLE) ? '0 : busy_cnt + 16'd1;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.sched_err = err_q;
`else
    assign timeout       = 1'b0;
    assign bus.sched_err = 1'b0;
`endif

    assign bus.sdram_wr_req  = wr_req_q;
    assign bus.sdram_rd_req  = rd_req_q;
    assign bus.sdram_wr_addr = wr_addr;
    assign bus.sdram_rd_addr = rd_addr;
    assign bus.wr_burst_len  = BURST_LEN;
    assign bus.rd_burst_len  = BURST_LEN;
    assign bus.wr_fifo_rd_en = bus.sdram_wr_ack;
    assign bus.rd_fifo_wr_en = bus.sdram_rd_ack;
    assign bus.fill_words    = fill;
endmodule
